// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wd;

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wd
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wd
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted stream bytes MSB first into 32-bit words and strobes on the last byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [23:0]           shift_q;

  // The completed word is taken combinationally so the top can register it on the 4th byte.
  assign word      = {shift_q, data};
  assign word_done = accept && !clr && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (clr) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= {shift_q[15:0], data};
      idx_q   <= word_done ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive instruction memory words.
// Optional inter-byte watchdog when IMEM_LOADER_TIMEOUT_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           core_hold,
  output logic           done,
  output logic           err
);

  // state  | meaning
  // IDLE   | waiting for start, core released
  // LEN_HI | expecting word-count MSB
  // LEN_LO | expecting word-count LSB, range check
  // DATA   | assembling words, writing memory
  // DONE   | one-cycle completion pulse
  // ERR    | bad length or timeout, core held until start

  state_t            state_q, state_d;
  logic              active, accept, word_done, timeout;
  logic              last_q, im_we_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       len, n_words_q, word_cnt_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wd_q, asm_word;

  assign active = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign accept = bus.in_valid && active;
  assign len    = {len_hi_q, bus.in_data};

  assign bus.in_ready = active;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wd    = im_wd_q;
  assign core_hold    = active || (state_q == ERR);
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q != DATA),
    .accept    (accept),
    .data      (bus.in_data),
    .word      (asm_word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  // Reloads on every byte and while not loading; terminal count 0 trips the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (accept || !active) begin
      wd_q <= WD_W'(TIMEOUT_CYC);
    end else if (wd_q != '0) begin
      wd_q <= wd_q - 1'b1;
    end
  end

  assign timeout = active && (wd_q == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LEN_HI;
      LEN_HI: begin
        if (timeout)     state_d = ERR;
        else if (accept) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (timeout) begin
          state_d = ERR;
        end else if (accept) begin
          if (len == 16'd0)                   state_d = DONE;
          else if ({1'b0, len} > 17'(DEPTH))  state_d = ERR;
          else                                state_d = DATA;
        end
      end
      // Completion waits for the final write cycle so done follows the last im_we.
      DATA: begin
        if (im_we_q && last_q) state_d = DONE;
        else if (timeout)      state_d = ERR;
      end
      DONE:    state_d = start ? LEN_HI : IDLE;
      ERR:     if (start) state_d = LEN_HI;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      im_we_q    <= 1'b0;
      last_q     <= 1'b0;
      len_hi_q   <= '0;
      n_words_q  <= '0;
      word_cnt_q <= '0;
      im_addr_q  <= '0;
      im_wd_q    <= '0;
    end else begin
      state_q <= state_d;
      im_we_q <= word_done;
      if (accept && (state_q == LEN_HI)) len_hi_q  <= bus.in_data;
      if (accept && (state_q == LEN_LO)) n_words_q <= len;
      if (state_q != DATA) begin
        word_cnt_q <= '0;
      end else if (word_done) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (word_done) begin
        im_addr_q <= word_cnt_q[ADDR_W-1:0];
        im_wd_q   <= asm_word;
        last_q    <= (word_cnt_q == n_words_q - 16'd1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard checked by a monitor.
module tb_imem_loader;

  localparam int ADDR_W      = 8;
  localparam int DEPTH       = 256;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.slave),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [31:0]        words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.im_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL wr_unexpected: observed write addr %0d data 0x%08h expected none",
               bus.im_addr, bus.im_wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.im_addr), 32'(mon_e[ADDR_W+31:32]));
        chk("wr_data", bus.im_wd, mon_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    if (gappy) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 64 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL handshake_timeout: in_ready observed 0 expected 1");
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Pushes expected writes for 'words' starting at address 0, then streams length and data.
  task automatic load_words(input bit gappy);
    logic [15:0] n;
    n = 16'(words.size());
    for (int i = 0; i < words.size(); i++) exp_q.push_back({ADDR_W'(i), words[i]});
    send_byte(n[15:8], gappy);
    send_byte(n[7:0], gappy);
    for (int i = 0; i < words.size(); i++)
      for (int k = 3; k >= 0; k--) send_byte(words[i][8*k +: 8], gappy);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64 && !done; i++) tick();
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int wr_base;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    tick();
    chk("rst_core_hold", 32'(core_hold), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_im_we", 32'(bus.im_we), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Two-word gap-free load with exact pulse timing
    pulse_start();
    chk("t1_hold_after_start", 32'(core_hold), 32'd1);
    chk("t1_ready_len_hi", 32'(bus.in_ready), 32'd1);
    words = '{32'h2008_0005, 32'hAC08_0000};
    load_words(1'b0);
    chk("t1_we_after_last", 32'(bus.im_we), 32'd1);
    chk("t1_ready_in_we_cycle", 32'(bus.in_ready), 32'd1);
    chk("t1_no_early_done", 32'(done), 32'd0);
    chk("t1_hold_in_we_cycle", 32'(core_hold), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd1);
    chk("t1_hold_drop_done", 32'(core_hold), 32'd0);
    chk("t1_we_low_done", 32'(bus.im_we), 32'd0);
    tick();
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_write_count", 32'(n_wr), 32'd2);

    // Zero-length load
    wr_base = n_wr;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t2_done_pulse", 32'(done), 32'd1);
    chk("t2_hold_low", 32'(core_hold), 32'd0);
    tick();
    chk("t2_done_one_cycle", 32'(done), 32'd0);
    chk("t2_no_writes", 32'(n_wr - wr_base), 32'd0);

    // Oversize length -> ERR, then recovery
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_hold", 32'(core_hold), 32'd1);
    chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) tick();
    chk("t3_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'd0);
    chk("t3_hold_len_hi", 32'(core_hold), 32'd1);
    words = '{32'hDEAD_BEEF};
    load_words(1'b0);
    tick();
    chk("t3_done", 32'(done), 32'd1);
    tick();

    // Three-word load with random gaps and an ignored start mid-DATA
    wr_base = n_wr;
    pulse_start();
    words = '{32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5};
    for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), words[i]});
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    for (int j = 0; j < 12; j++) begin
      if (j == 5) begin
        bus.in_valid = 1'b0;
        pulse_start();
        chk("t4_hold_after_start", 32'(core_hold), 32'd1);
        chk("t4_ready_after_start", 32'(bus.in_ready), 32'd1);
      end
      send_byte(words[j/4][8*(3-(j%4)) +: 8], 1'b1);
    end
    wait_done("t4_done");
    chk("t4_write_count", 32'(n_wr - wr_base), 32'd3);
    tick();

    // Reset mid-load after 6 data bytes
    pulse_start();
    exp_q.push_back({ADDR_W'(0), 32'h1122_3344});
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_hold_rst", 32'(core_hold), 32'd0);
    chk("t5_ready_rst", 32'(bus.in_ready), 32'd0);
    chk("t5_addr_rst", 32'(bus.im_addr), 32'd0);
    chk("t5_wd_rst", bus.im_wd, 32'd0);
    chk("t5_flags_rst", {29'd0, bus.im_we, done, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    words = '{32'hCAFE_F00D};
    load_words(1'b0);
    tick();
    chk("t5_done_after_rst", 32'(done), 32'd1);
    tick();

    // Stall mid-word: watchdog behaviour depends on build
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
`ifdef IMEM_LOADER_TIMEOUT_EN
    repeat (TIMEOUT_CYC) tick();
    chk("t6_no_err_before_tc", 32'(err), 32'd0);
    tick();
    chk("t6_err_timeout", 32'(err), 32'd1);
    chk("t6_hold_timeout", 32'(core_hold), 32'd1);
`else
    repeat (100) tick();
    chk("t6_no_err_stall", 32'(err), 32'd0);
    chk("t6_hold_stall", 32'(core_hold), 32'd1);
    chk("t6_ready_stall", 32'(bus.in_ready), 32'd1);
`endif
    chk("t6_no_write_stall", 32'(bus.im_we), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
